// File: rtl/inst_loader.sv
// inst_loader: boot-time instruction RAM writer.
// Takes a UART byte stream (32-bit little-endian word count, then that many
// little-endian words). Each word is written to sequential RAM word addresses.
// The core is held in reset until the whole image has been consumed.
module inst_loader #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] csum_q, csum_d;
  logic        we_q, we_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;

  logic        last_byte;
  logic [31:0] word_in;
  logic        in_range;

  assign last_byte = rx_valid && (bcnt_q == 2'd3);
  assign word_in   = {rx_data, sh_q};
  assign in_range  = ({1'b0, wcnt_q} < DEPTH);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave DATA only once the final word's write cycle has occurred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          state_d = (word_in == 32'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (pend_q && ((wcnt_q + 32'd1) == len_q)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    done      = (state_q == S_DONE);
    core_hold = (state_q != S_DONE);
  end

  // Datapath next values: byte assembly, header capture, word write, checksum.
  // The word counter advances in the cycle the write is presented, so the
  // RAM address stays stable during mem_we and moves on afterwards.
  always_comb begin
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;
    err_d   = err_q;
    we_d    = 1'b0;
    pend_d  = 1'b0;

    if (rx_valid && (state_q != S_DONE)) begin
      sh_d   = word_in[31:8];
      bcnt_d = bcnt_q + 2'd1;
    end

    if (state_q == S_LEN && last_byte) begin
      len_d  = word_in;
      wcnt_d = '0;
      err_d  = ({1'b0, word_in} > DEPTH);
    end

    if (state_q == S_DATA) begin
      if (pend_q) begin
        wcnt_d = wcnt_q + 32'd1;
      end
      if (last_byte) begin
        wdata_d = word_in;
        we_d    = in_range;
        pend_d  = 1'b1;
        csum_d  = csum_q + word_in;
      end
    end

    if (state_d != state_q) begin
      bcnt_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_waddr = wcnt_q[ADDR_WIDTH-1:0];
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign checksum  = csum_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: two instances (full-size and a 4-word RAM) share
// one byte stream; a stream-level model predicts writes, timing and flags.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        we0, hold0, done0, err0;
  logic [14:0] waddr0;
  logic [31:0] wdata0, cs0;
  logic        we1, hold1, done1, err1;
  logic [1:0]  waddr1;
  logic [31:0] wdata1, cs1;

  inst_loader dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(we0), .mem_waddr(waddr0), .mem_wdata(wdata0),
    .core_hold(hold0), .done(done0), .err(err0), .checksum(cs0)
  );

  inst_loader #(.ADDR_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(we1), .mem_waddr(waddr1), .mem_wdata(wdata1),
    .core_hold(hold1), .done(done1), .err(err1), .checksum(cs1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wq0[$];
  wr_t wq1[$];
  int  dc0 = -1;
  int  dc1 = -1;

  // Observed write pulses and first done cycle, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t t;
    if (!rst_n) begin
      wq0.delete();
      wq1.delete();
      dc0 = -1;
      dc1 = -1;
    end else begin
      if (we0) begin
        t.cyc = cyc; t.addr = int'(waddr0); t.data = wdata0;
        wq0.push_back(t);
      end
      if (we1) begin
        t.cyc = cyc; t.addr = int'(waddr1); t.data = wdata1;
        wq1.push_back(t);
      end
      if (done0 && dc0 < 0) dc0 = cyc;
      if (done1 && dc1 < 0) dc1 = cyc;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         sc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst.we0", {63'd0, we0}, 64'd0);
    chk("rst.addr0", {49'd0, waddr0}, 64'd0);
    chk("rst.data0", {32'd0, wdata0}, 64'd0);
    chk("rst.done0", {63'd0, done0}, 64'd0);
    chk("rst.err0", {63'd0, err0}, 64'd0);
    chk("rst.cs0", {32'd0, cs0}, 64'd0);
    chk("rst.hold0", {63'd0, hold0}, 64'd1);
    chk("rst.we1", {63'd0, we1}, 64'd0);
    chk("rst.done1", {63'd0, done1}, 64'd0);
    chk("rst.cs1", {32'd0, cs1}, 64'd0);
    chk("rst.hold1", {63'd0, hold1}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    sc.delete();
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    sb.push_back(b);
    sc.push_back(cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w, input int gap);
    put(w[7:0], gap);
    put(w[15:8], gap);
    put(w[23:16], gap);
    put(w[31:24], gap);
  endtask

  // Reference: parse the recorded byte stream, predict every write and flag.
  task automatic check_dut(input int idx);
    wr_t         got[$];
    wr_t         exp[$];
    wr_t         t;
    longint      n, depth;
    logic [31:0] sum, w;
    int          edc, dcyc, aw, nw;
    logic        dn, er, hold;
    logic [31:0] cs;
    string       tag;
    if (idx == 0) begin
      got = wq0; aw = 15; dn = done0; er = err0; hold = hold0; cs = cs0; dcyc = dc0; tag = "d15";
    end else begin
      got = wq1; aw = 2; dn = done1; er = err1; hold = hold1; cs = cs1; dcyc = dc1; tag = "d2";
    end
    depth = 64'd1 << aw;
    n = longint'({sb[3], sb[2], sb[1], sb[0]});
    sum = 32'd0;
    nw = int'(n);
    for (int i = 0; i < nw; i++) begin
      w = {sb[4*i+7], sb[4*i+6], sb[4*i+5], sb[4*i+4]};
      sum = sum + w;
      if (longint'(i) < depth) begin
        t.cyc = sc[4*i+7]; t.addr = i; t.data = w;
        exp.push_back(t);
      end
    end
    edc = (nw == 0) ? sc[3] : sc[4*nw+3] + 1;
    chk({tag, ".nwrites"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s.w%0d.cyc", tag, i), 64'(got[i].cyc), 64'(exp[i].cyc));
      chk($sformatf("%s.w%0d.addr", tag, i), 64'(got[i].addr), 64'(exp[i].addr));
      chk($sformatf("%s.w%0d.data", tag, i), {32'd0, got[i].data}, {32'd0, exp[i].data});
    end
    chk({tag, ".checksum"}, {32'd0, cs}, {32'd0, sum});
    chk({tag, ".done"}, {63'd0, dn}, 64'd1);
    chk({tag, ".done_cyc"}, 64'(dcyc), 64'(edc));
    chk({tag, ".err"}, {63'd0, er}, {63'd0, (n > depth)});
    chk({tag, ".hold"}, {63'd0, hold}, 64'd0);
  endtask

  task automatic finish_session();
    repeat (8) @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int n, g;

    // Basic load.
    do_reset();
    put_word(32'd2, 1);
    put_word(32'h00100513, 1);
    put_word(32'h0000006F, 1);
    finish_session();
    chk("basic.cs", {32'd0, cs0}, 64'h00100582);

    // Back-to-back bytes.
    do_reset();
    put_word(32'd3, 0);
    put_word(32'hDEADBEEF, 0);
    put_word(32'h01234567, 0);
    put_word(32'h89ABCDEF, 0);
    finish_session();

    // Zero length, trailing bytes ignored.
    do_reset();
    put_word(32'd0, 0);
    put_word(32'hDDCCBBAA, 1);
    finish_session();

    // Overflow on the 4-word instance.
    do_reset();
    put_word(32'd5, 0);
    for (int i = 1; i <= 5; i++) put_word(32'(i), 2);
    finish_session();
    chk("ovf.cs", {32'd0, cs1}, 64'd15);
    chk("ovf.err", {63'd0, err1}, 64'd1);

    // Reset mid-word, then full resend.
    do_reset();
    put_word(32'd1, 0);
    put(8'h78, 0);
    put(8'h56, 0);
    do_reset();
    put_word(32'd1, 0);
    put_word(32'h12345678, 0);
    finish_session();

    // Checksum wrap.
    do_reset();
    put_word(32'd2, 0);
    put_word(32'hFFFFFFFF, 1);
    put_word(32'h00000002, 0);
    finish_session();
    chk("wrap.cs", {32'd0, cs0}, 64'd1);

    // Randomized sessions.
    for (int s = 0; s < 20; s++) begin
      do_reset();
      n = $urandom_range(0, 7);
      g = $urandom_range(0, 2);
      put_word(32'(n), g);
      for (int i = 0; i < n; i++) put_word($urandom, $urandom_range(0, 2));
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) put(8'($urandom), $urandom_range(0, 1));
      finish_session();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the instruction memory. Receives a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and drives the instruction RAM write port with sequential word addresses. It holds the core in reset until the whole program image has been written. This replaces the `$readmemh` initialisation on hardware.

## Interface

Parameters:

- `ADDR_WIDTH`, 15: word-address width. Instruction RAM depth is 2^ADDR_WIDTH words (32768).

Ports:

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `mem_we`  out  1  instruction RAM write enable, one-cycle pulse per word
- `mem_waddr`  out  ADDR_WIDTH  word address; byte address = `mem_waddr` << 2
- `mem_wdata`  out  32  instruction word
- `core_hold`  out  1  high keeps the CPU in reset; low once loading is complete
- `done`  out  1  sticky: image fully received
- `err`  out  1  sticky: declared length exceeded RAM depth
- `checksum`  out  32  running sum mod 2^32 of all received data words

## Operation

- Stream format:
  - 4-byte length header `N`, in words, little-endian (first byte = bits 7:0).
  - Then N words, each 4 bytes, little-endian.
- States:
  - `LEN`: the reset state. Collects 4 header bytes.
    - N == 0 → `DONE`.
    - Otherwise → `DATA`, with the word counter cleared.
  - `DATA`: collects bytes into the word shift register.
    - On the 4th byte of a word, register `mem_wdata`/`mem_waddr` and pulse `mem_we`.
    - `mem_waddr` increments after each write.
    - After word N is written → `DONE`.
  - `DONE`: all further `rx_valid` strobes are ignored. The block stays here until reset.
- Byte counter: 2 bits, wraps 3→0 at each word boundary. It is cleared on every state transition.
- Overflow rule (N > 2^ADDR_WIDTH):
  - `err` is set in the cycle after the header completes.
  - All N words are still consumed and added to `checksum`.
  - `mem_we` is suppressed for word index ≥ 2^ADDR_WIDTH, so addresses never wrap and overwrite word 0.
- Word counter width: 32 bits, compared against N. `mem_waddr` is its low ADDR_WIDTH bits.
- `checksum`: a 32-bit sum that wraps mod 2^32. It is updated in the same cycle `mem_we` would be asserted, including words whose write is suppressed.
- `core_hold` = !`done`.

## Timing

- Reset values (asynchronous, immediate on `rst_n` low):
  - state = `LEN`
  - `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0
  - `done`=0, `err`=0, `checksum`=0
  - `core_hold`=1
- `rx_valid` may be high on consecutive cycles; every strobe is accepted. There is no backpressure.
- Write latency: `mem_we` is high for exactly one cycle, the cycle after the edge that sampled the 4th byte of the word.
  - `mem_waddr`/`mem_wdata` are valid during that cycle.
  - `mem_waddr` shows the next address in the following cycle.
- `done` rises on the same edge that deasserts the last `mem_we`, i.e. one cycle after the final write pulse.
  - For N == 0, `done` rises one cycle after the 4th header byte is sampled.
- `core_hold` falls together with `done`.
- If `rst_n` is asserted mid-stream, all partial bytes and words are discarded and the header is expected again.
- Bytes arriving in `DONE` cause no output change.

## Test plan

- **Basic load:** send N=2 (`02 00 00 00`), then `13 05 10 00` and `6F 00 00 00` →
  - pulse 1: `mem_we` with addr 0, data 0x00100513.
  - pulse 2: `mem_we` with addr 1, data 0x0000006F.
  - `done`=1 and `core_hold`=0 one cycle after pulse 2.
  - `checksum`=0x00100582.
- **Back-to-back bytes:** header plus 3 words on consecutive `rx_valid` cycles → exactly 3 `mem_we` pulses, spaced 4 cycles apart, addresses 0,1,2.
- **Zero length:** `00 00 00 00` → no `mem_we`; `done`=1 one cycle after the 4th byte; subsequent bytes `AA BB CC DD` produce no writes.
- **Overflow:** ADDR_WIDTH=2, N=5, words 1..5 →
  - `err`=1 after the header.
  - Writes only to addresses 0..3, with data 1..4.
  - No 5th `mem_we`.
  - `checksum`=15 and `done`=1.
- **Reset mid-word:** N=1, send 2 data bytes, pulse `rst_n` low → all outputs return to reset values. Resending the full stream `01 00 00 00 78 56 34 12` → one write: addr 0, data 0x12345678.
- **Checksum wrap:** N=2, words 0xFFFFFFFF and 0x00000002 → `checksum`=0x00000001.
